// File: rtl/serial_byte_receiver_pkg.sv
// Shared defaults and FSM state encoding for the dataIn serial byte receiver.
package serial_byte_receiver_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int TIMEOUT_DEF    = 1024;
    localparam int FIFO_DEPTH_DEF = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/serial_byte_receiver_if.sv
// Serial input link plus byte valid/ready output bundle of the receiver.
interface serial_byte_receiver_if #(
    parameter int DATA_W = 8
);

    logic              dataIn_ready;
    logic              dataIn_bits;
    logic [DATA_W-1:0] byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic              frame_err;
    logic              overflow;

    modport master (
        output dataIn_ready,
        output dataIn_bits,
        output byte_ready,
        input  byte_data,
        input  byte_valid,
        input  frame_err,
        input  overflow
    );

    modport slave (
        input  dataIn_ready,
        input  dataIn_bits,
        input  byte_ready,
        output byte_data,
        output byte_valid,
        output frame_err,
        output overflow
    );

endinterface

// File: rtl/serial_byte_receiver_fifo.sv
// Small synchronous FIFO; the head word is held after the last pop so the output stays steady when empty.
module sync_fifo_small
    import serial_byte_receiver_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? hold_q : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            hold_d   = mem_q[rd_ptr_q];
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/serial_byte_receiver.sv
// Deserializes the LSB-first dataIn stream into words, buffers them and flags timeouts and drops.
module serial_byte_receiver
    import serial_byte_receiver_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input logic                   clk,
    input logic                   rst_n,
    serial_byte_receiver_if.slave rx
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam int GAP_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TIMEOUT - 1);
    localparam logic [0:0] S_IDLE  = IDLE;
    localparam logic [0:0] S_SHIFT = SHIFT;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              frame_err_q, frame_err_d;
    logic              overflow_q, overflow_d;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        if (rx.dataIn_ready) shreg_d = {rx.dataIn_bits, shreg_q[DATA_W-1:1]};
        case (state_q)
            S_IDLE: begin
                if (rx.dataIn_ready) begin
                    bit_cnt_d = CNT_W'(1);
                    gap_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A strobe always beats the timeout in the same cycle.
                if (rx.dataIn_ready) begin
                    gap_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        push      = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (gap_cnt_q == GAP_MAX) begin
                    frame_err_d = 1'b1;
                    bit_cnt_d   = '0;
                    gap_cnt_d   = '0;
                    state_d     = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pop        = rx.byte_valid && rx.byte_ready;
    assign overflow_d = push && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    sync_fifo_small #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (shreg_d),
        .pop_i   (pop),
        .data_o  (rx.byte_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rx.byte_valid = !fifo_empty;
    assign rx.frame_err  = frame_err_q;
    assign rx.overflow   = overflow_q;

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (rx.byte_valid && !rx.byte_ready) |=> $stable(rx.byte_data));

endmodule
